// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } chan_state_e;

  localparam int CLK_DIV_DEFAULT_WIDTH    = 8;
  localparam int CLK_DIV_DEFAULT_CHANNELS = 4;

endpackage

// File: rtl/clk_div_multi_if.sv
// Bundle of the per-channel control and status vectors of clk_div_multi.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int WIDTH    = CLK_DIV_DEFAULT_WIDTH,
  parameter int CHANNELS = CLK_DIV_DEFAULT_CHANNELS
);

  logic [CHANNELS-1:0]       clk_en;
  logic [CHANNELS*WIDTH-1:0] div_ratio;
  logic [CHANNELS-1:0]       div_clk;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       active;

  modport master (output clk_en, div_ratio, input div_clk, tick, active);
  modport slave  (input clk_en, div_ratio, output div_clk, tick, active);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/HIGH/LOW FSM, phase counter, active ratio and tick.
// Tick register exists only when CLK_DIV_MULTI_TICK_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH = CLK_DIV_DEFAULT_WIDTH
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_active
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  chan_state_e      r_state, w_nxt_state;
  logic [WIDTH-1:0] r_cnt, w_nxt_cnt;
  logic [WIDTH-1:0] r_ratio, w_nxt_ratio;
  logic             r_out, w_nxt_out;
  logic             w_ratio_ok;
  logic [WIDTH-1:0] w_high_len;
  logic [WIDTH-1:0] w_low_len;

  // Ratios 0 and 1 cannot be divided and force the bypass path.
  assign w_ratio_ok = |i_div_ratio[WIDTH-1:1];
  assign w_high_len = (r_ratio >> 1) + {{(WIDTH-1){1'b0}}, r_ratio[0]};
  assign w_low_len  = r_ratio >> 1;

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ratio <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_ratio <= w_nxt_ratio;
      r_out   <= w_nxt_out;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_ratio = r_ratio;
    w_nxt_out   = r_out;
    case (r_state)
      ST_IDLE: begin
        w_nxt_cnt = '0;
        w_nxt_out = 1'b0;
        if (i_clk_en && w_ratio_ok) begin
          w_nxt_state = ST_HIGH;
          w_nxt_ratio = i_div_ratio;
          w_nxt_out   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!i_clk_en) begin
          w_nxt_state = ST_IDLE;
          w_nxt_out   = 1'b0;
          w_nxt_cnt   = '0;
        end else if (r_cnt == w_high_len - ONE) begin
          w_nxt_state = ST_LOW;
          w_nxt_out   = 1'b0;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + ONE;
        end
      end
      ST_LOW: begin
        if (!i_clk_en) begin
          w_nxt_state = ST_IDLE;
          w_nxt_out   = 1'b0;
          w_nxt_cnt   = '0;
        end else if (r_cnt == w_low_len - ONE) begin
          // Period boundary: the only place a new ratio is accepted.
          w_nxt_ratio = i_div_ratio;
          w_nxt_cnt   = '0;
          if (w_ratio_ok) begin
            w_nxt_state = ST_HIGH;
            w_nxt_out   = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_out   = 1'b0;
          end
        end else begin
          w_nxt_cnt = r_cnt + ONE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
        w_nxt_out   = 1'b0;
      end
    endcase
  end

  assign o_active  = (r_state != ST_IDLE);
  assign o_div_clk = (!i_rst_n || r_state == ST_IDLE) ? i_ref_clk : r_out;

`ifdef CLK_DIV_MULTI_TICK_EN
  logic r_tick;
  logic w_start;

  assign w_start = (w_nxt_state == ST_HIGH) && (r_state != ST_HIGH);

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_start;
    end
  end

  assign o_tick = r_tick;
`else
  assign o_tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Array of independent clock-divider channels sharing one reference clock.
// Tick outputs are generated only when CLK_DIV_MULTI_TICK_EN is defined.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int WIDTH    = CLK_DIV_DEFAULT_WIDTH,
  parameter int CHANNELS = CLK_DIV_DEFAULT_CHANNELS
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS-1:0]       i_clk_en,
  input  logic [CHANNELS*WIDTH-1:0] i_div_ratio,
  output logic [CHANNELS-1:0]       o_div_clk,
  output logic [CHANNELS-1:0]       o_tick,
  output logic [CHANNELS-1:0]       o_active
);

  genvar gk;
  generate
    for (gk = 0; gk < CHANNELS; gk++) begin : g_chan
      clk_div_chan #(
        .WIDTH(WIDTH)
      ) u_chan (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_en   (i_clk_en[gk]),
        .i_div_ratio(i_div_ratio[gk*WIDTH +: WIDTH]),
        .o_div_clk  (o_div_clk[gk]),
        .o_tick     (o_tick[gk]),
        .o_active   (o_active[gk])
      );
    end
  endgenerate

endmodule
